// File: rtl/coord_stream_collector_pkg.sv
// Shared types for the coordinate stream collector: FSM state encoding and
// the default pixel entry layout carried through the pixel FIFO.
package coord_collector_pkg;

  localparam int COORD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  typedef struct packed {
    logic signed [COORD_WIDTH-1:0] x;
    logic signed [COORD_WIDTH-1:0] y;
  } coord_t;

endpackage

// File: rtl/coord_stream_collector_fifo.sv
// Synchronous FIFO of coordinate entries. Push is ignored when full and pop
// is ignored when empty; pointers wrap naturally because DEPTH is a power of two.
module coord_fifo
  import coord_collector_pkg::*;
#(
  parameter type entry_t = coord_t,
  parameter int  DEPTH   = 4,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  entry_t           wr_data,
  output entry_t           rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next-state for storage, pointers and occupancy; push+pop keeps count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; reset flushes the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/coord_stream_collector.sv
// Draw engine front end: accepts a host command, pulses the generator start
// with latched arguments, buffers the generator's coordinate stream and
// forwards pixels downstream, counting deliveries.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; a source holds valid and payload stable until it is taken, and
// ready never depends combinationally on the same port's valid.
module coord_stream_collector
  import coord_collector_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 _clock,
  input  logic                 _reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WIDTH-1:0]     cmd_arg0,
  input  logic [WIDTH-1:0]     cmd_arg1,
  input  logic [WIDTH-1:0]     cmd_arg2,
  output logic                 gen_start,
  output logic [WIDTH-1:0]     gen_arg0,
  output logic [WIDTH-1:0]     gen_arg1,
  output logic [WIDTH-1:0]     gen_arg2,
  output logic                 gen_ready,
  input  logic                 gen_valid,
  input  logic                 gen_done,
  input  logic [WIDTH-1:0]     gen_out_0,
  input  logic [WIDTH-1:0]     gen_out_1,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic [WIDTH-1:0]     pix_x,
  output logic [WIDTH-1:0]     pix_y,
  output logic                 busy,
  output logic                 finished,
  output logic [CNT_WIDTH-1:0] pixel_count,
  output logic [1:0]           dbg_state
);

  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
  } pix_t;

  state_e               state_q, state_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 gen_start_q, gen_start_d;
  logic                 busy_q, busy_d;
  logic                 finished_q, finished_d;
  logic [WIDTH-1:0]     arg0_q, arg0_d, arg1_q, arg1_d, arg2_q, arg2_d;
  logic [CNT_WIDTH-1:0] pixel_count_q, pixel_count_d;

  logic                 accept, push, pop;
  logic                 fifo_full, fifo_empty;
  logic [FCNT_W-1:0]    fifo_count;
  pix_t                 fifo_in, fifo_head;

  // Command taken only when the registered ready is up (not in the cycle
  // straight out of reset). gen_ready uses registered occupancy only.
  assign accept    = (state_q == IDLE) && cmd_ready_q && cmd_valid;
  assign gen_ready = (state_q == STREAM) && !fifo_full;
  assign push      = gen_valid && gen_ready;
  assign pix_valid = !fifo_empty;
  assign pop       = pix_valid && pix_ready;
  assign fifo_in   = '{x: gen_out_0, y: gen_out_1};

  coord_fifo #(
    .entry_t (pix_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk     (_clock),
    .rst_n   (_reset_n),
    .push    (push),
    .pop     (pop),
    .wr_data (fifo_in),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Sequencing, registered status outputs, argument latch and pixel counter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   state_d = STREAM;
      STREAM:  if (gen_done && gen_ready) state_d = DRAIN;
      DRAIN:   if (fifo_count == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    gen_start_d = (state_d == START);
    busy_d      = (state_d != IDLE);
    finished_d  = (state_q == DRAIN) && (state_d == IDLE);

    arg0_d = arg0_q;
    arg1_d = arg1_q;
    arg2_d = arg2_q;
    pixel_count_d = pixel_count_q;
    if (accept) begin
      arg0_d = cmd_arg0;
      arg1_d = cmd_arg1;
      arg2_d = cmd_arg2;
      pixel_count_d = '0;
    end else if (pop && (pixel_count_q != '1)) begin
      pixel_count_d = pixel_count_q + 1'b1;
    end
  end

  // Control registers; reset abandons any command without a finished pulse.
  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      gen_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      finished_q    <= 1'b0;
      arg0_q        <= '0;
      arg1_q        <= '0;
      arg2_q        <= '0;
      pixel_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      gen_start_q   <= gen_start_d;
      busy_q        <= busy_d;
      finished_q    <= finished_d;
      arg0_q        <= arg0_d;
      arg1_q        <= arg1_d;
      arg2_q        <= arg2_d;
      pixel_count_q <= pixel_count_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign gen_start   = gen_start_q;
  assign busy        = busy_q;
  assign finished    = finished_q;
  assign gen_arg0    = arg0_q;
  assign gen_arg1    = arg1_q;
  assign gen_arg2    = arg2_q;
  assign pixel_count = pixel_count_q;
  assign pix_x       = fifo_head.x;
  assign pix_y       = fifo_head.y;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_coord_stream_collector.sv
// Bench for coord_stream_collector: a queue-based reference model of the
// pixel buffer and command life cycle, driven by directed and random runs.
module tb_coord_stream_collector;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [W-1:0]  cmd_arg0 = '0, cmd_arg1 = '0, cmd_arg2 = '0;
  logic          gen_start;
  logic [W-1:0]  gen_arg0, gen_arg1, gen_arg2;
  logic          gen_ready;
  logic          gen_valid = 1'b0;
  logic          gen_done = 1'b0;
  logic [W-1:0]  gen_out_0 = '0, gen_out_1 = '0;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic [W-1:0]  pix_x, pix_y;
  logic          busy, finished;
  logic [CW-1:0] pixel_count;
  logic [1:0]    dbg_state;

  coord_stream_collector #(
    .WIDTH(W), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    ._clock(clk), ._reset_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_arg0(cmd_arg0), .cmd_arg1(cmd_arg1), .cmd_arg2(cmd_arg2),
    .gen_start(gen_start),
    .gen_arg0(gen_arg0), .gen_arg1(gen_arg1), .gen_arg2(gen_arg2),
    .gen_ready(gen_ready), .gen_valid(gen_valid), .gen_done(gen_done),
    .gen_out_0(gen_out_0), .gen_out_1(gen_out_1),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y),
    .busy(busy), .finished(finished), .pixel_count(pixel_count),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int passes = 0;
  logic [2*W-1:0] exp_q[$];   // pixels buffered, {x,y}
  logic [2*W-1:0] src_q[$];   // pixels the model generator still has to emit
  bit  m_stream = 0;          // generator output being accepted
  bit  m_drain  = 0;          // generator done, buffer emptying
  int  m_cnt    = 0;          // expected pixel_count
  int  pushed   = 0;
  bit  last_push = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One streaming/draining cycle: check outputs against the model, clock,
  // then advance the model by the transfers that happened.
  task automatic step();
    int sz;
    bit exp_gr, pop, push, dhs, exp_fin;
    sz     = exp_q.size();
    exp_gr = m_stream && (sz < DEPTH);
    chk("gen_ready", 64'(gen_ready), 64'(exp_gr));
    chk("pix_valid", 64'(pix_valid), 64'(sz != 0));
    if (sz != 0) chk("pix_xy", {pix_x, pix_y}, exp_q[0]);
    chk("gen_start_quiet", 64'(gen_start), 64'(0));
    pop  = (sz != 0) && pix_ready;
    push = gen_valid && exp_gr;
    dhs  = gen_done && exp_gr;
    last_push = push;
    tick();
    if (pop) begin
      void'(exp_q.pop_front());
      if (m_cnt < CMAX) m_cnt++;
    end
    if (push) begin
      exp_q.push_back({gen_out_0, gen_out_1});
      pushed++;
    end
    exp_fin = 0;
    if (m_drain && sz == 0) begin
      m_drain = 0;
      exp_fin = 1;
    end
    if (dhs) begin
      m_stream = 0;
      m_drain  = 1;
    end
    chk("finished", 64'(finished), 64'(exp_fin));
    chk("busy", 64'(busy), 64'(m_stream || m_drain));
    chk("cmd_ready", 64'(cmd_ready), 64'(!(m_stream || m_drain)));
    chk("pixel_count", 64'(pixel_count), 64'(m_cnt));
  endtask

  // ---------------- driver tasks ----------------
  // pr_mode: 0 random, 1 always ready, 2 ready for pr_hold cycles then low,
  // 3 low for pr_hold cycles then ready.
  task automatic run_cmd(input logic [W-1:0] a0, input logic [W-1:0] a1,
                         input logic [W-1:0] a2, input bit done_last,
                         input bit gen_full, input int pr_mode,
                         input int pr_hold, input int abort_at);
    int guard = 0;
    int n = 0;
    bit hold = 0;
    chk("cmd_ready_before", 64'(cmd_ready), 64'(1));
    cmd_valid = 1; cmd_arg0 = a0; cmd_arg1 = a1; cmd_arg2 = a2;
    tick();
    m_cnt = 0;
    // arguments must stay latched even while the host bus changes
    cmd_valid = 1; cmd_arg0 = $urandom; cmd_arg1 = $urandom; cmd_arg2 = $urandom;
    chk("gen_start_pulse", 64'(gen_start), 64'(1));
    chk("gen_arg0", 64'(gen_arg0), 64'(a0));
    chk("gen_arg1", 64'(gen_arg1), 64'(a1));
    chk("gen_arg2", 64'(gen_arg2), 64'(a2));
    chk("cmd_ready_start", 64'(cmd_ready), 64'(0));
    chk("busy_start", 64'(busy), 64'(1));
    chk("gen_ready_start", 64'(gen_ready), 64'(0));
    chk("pixel_count_clr", 64'(pixel_count), 64'(0));
    tick();
    m_stream = 1;
    pushed = 0;
    while ((m_stream || m_drain) && guard < 2000) begin
      cmd_valid = 1'($urandom_range(0, 1));
      if (m_stream) begin
        if (!hold) gen_valid = (src_q.size() > 0) && (gen_full || ($urandom_range(0, 3) != 0));
        if (gen_valid) {gen_out_0, gen_out_1} = src_q[0];
        gen_done = done_last ? (gen_valid && src_q.size() == 1) : (src_q.size() == 0);
      end else begin
        gen_valid = 0;
        gen_done  = 0;
      end
      case (pr_mode)
        1:       pix_ready = 1;
        2:       pix_ready = (n < pr_hold);
        3:       pix_ready = (n >= pr_hold);
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      step();
      if (last_push) begin
        void'(src_q.pop_front());
        hold = 0;
      end else begin
        hold = gen_valid;
      end
      n++;
      guard++;
      if (abort_at > 0 && exp_q.size() >= abort_at && m_cnt > 0) begin
        cmd_valid = 0; gen_valid = 0; gen_done = 0; pix_ready = 0;
        return;
      end
    end
    cmd_valid = 0; gen_valid = 0; gen_done = 0;
    chk("run_bounded", 64'(guard < 2000), 64'(1));
    chk("gen_arg0_hold", 64'(gen_arg0), 64'(a0));
    chk("gen_arg2_hold", 64'(gen_arg2), 64'(a2));
  endtask

  task automatic fill_random(input int n);
    src_q.delete();
    for (int i = 0; i < n; i++) src_q.push_back({32'($urandom), 32'($urandom)});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset held
    tick();
    tick();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_gen_start", 64'(gen_start), 64'(0));
    chk("rst_gen_ready", 64'(gen_ready), 64'(0));
    chk("rst_pix_valid", 64'(pix_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_finished", 64'(finished), 64'(0));
    chk("rst_pixel_count", 64'(pixel_count), 64'(0));
    chk("rst_gen_arg0", 64'(gen_arg0), 64'(0));
    rst_n = 1;
    tick();
    chk("rel_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rel_busy", 64'(busy), 64'(0));

    // circle points, full throughput, done after last point
    src_q.delete();
    src_q.push_back({32'd58, 32'd50});
    src_q.push_back({32'd50, 32'd58});
    src_q.push_back({32'd42, 32'd50});
    run_cmd(32'd50, 32'd50, 32'd8, 0, 1, 1, 0, 0);
    chk("circle_count", 64'(pixel_count), 64'(3));
    step();  // idle cycle: no second finished pulse

    // backpressure: 6 points with downstream stalled, then released
    fill_random(6);
    run_cmd(32'd1, 32'd2, 32'd3, 0, 1, 3, 12, 0);
    chk("stall_count", 64'(pixel_count), 64'(6));

    // back-to-back command in the finished cycle, final point with done
    fill_random(3);
    src_q.push_back({32'd54, 32'd60});
    run_cmd(32'hFFFF_FFF0, 32'd7, 32'd9, 1, 0, 0, 0, 0);
    chk("done_last_count", 64'(pixel_count), 64'(4));

    // random commands
    for (int k = 0; k < 5; k++) begin
      fill_random($urandom_range(1, 9));
      run_cmd($urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, 1), 0, 0);
      if ($urandom_range(0, 1) == 1) step();
    end

    // counter saturation
    fill_random(20);
    run_cmd(32'd4, 32'd5, 32'd6, 0, 1, 1, 0, 0);
    chk("sat_count", 64'(pixel_count), 64'(CMAX));

    // reset mid-stream with two entries buffered
    fill_random(6);
    run_cmd(32'd11, 32'd12, 32'd13, 0, 1, 2, 3, 2);
    chk("abort_buffered", 64'(exp_q.size()), 64'(2));
    #2;
    rst_n = 0;
    #1;
    chk("abort_pix_valid", 64'(pix_valid), 64'(0));
    chk("abort_pixel_count", 64'(pixel_count), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_gen_ready", 64'(gen_ready), 64'(0));
    exp_q.delete();
    src_q.delete();
    m_stream = 0; m_drain = 0; m_cnt = 0;
    tick();
    chk("abort_finished_rst", 64'(finished), 64'(0));
    rst_n = 1;
    tick();
    chk("abort_finished_rel", 64'(finished), 64'(0));
    chk("abort_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("abort_pix_valid2", 64'(pix_valid), 64'(0));

    // works normally afterwards
    fill_random(2);
    run_cmd(32'd21, 32'd22, 32'd23, 1, 1, 1, 0, 0);
    chk("post_reset_count", 64'(pixel_count), 64'(2));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
